// File: rtl/mem_grant_arbiter_pkg.sv
// mem_grant_arbiter_pkg
// ---------------------
// Shared declarations for the round-robin memory grant arbiter: the FSM state
// encoding, core-count helpers and a one-hot conversion helper.
// No ports (package).

// Fallback values, used only when the shared SharedInc header has not already
// provided the core-count macros.
`ifndef NUM_OF_CORES
`define NUM_OF_CORES 4
`endif
`ifndef CORE_ID_SIZE
`define CORE_ID_SIZE 2
`endif
`ifndef CORES_RANGE
`define CORES_RANGE `NUM_OF_CORES-1:0
`endif
`ifndef CORE_ID_RANGE
`define CORE_ID_RANGE `CORE_ID_SIZE-1:0
`endif

package mem_grant_arbiter_pkg;

    localparam int NUM_CORES = `NUM_OF_CORES;
    localparam int ID_W      = `CORE_ID_SIZE;

    // Arbiter FSM encoding, kept local to this block.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Turns a core id into the one-hot grant vector driven back to the cores.
    function automatic logic [`CORES_RANGE] onehot(input logic [`CORE_ID_RANGE] id);
        logic [`CORES_RANGE] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_next_id.sv
// rr_next_id
// ----------
// Combinational round-robin search: finds the first set bit of i_mask scanning
// i_start+1, i_start+2, ... with wrap modulo the core count; i_start itself is
// examined last.
// Ports:
//   i_mask    in  per-core candidate bits
//   i_start   in  id after which the search begins
//   o_next_id out first set id found (equals i_start when none found)
//   o_none    out high when i_mask is all zero

import mem_grant_arbiter_pkg::*;

module rr_next_id (
    input  logic [`CORES_RANGE]   i_mask,
    input  logic [`CORE_ID_RANGE] i_start,
    output logic [`CORE_ID_RANGE] o_next_id,
    output logic                  o_none
);

    // The wrap is done by a conditional subtract rather than a modulo so that
    // non-power-of-two core counts still map onto valid ids.
    always_comb begin
        int idx;
        idx       = 0;
        o_next_id = i_start;
        o_none    = 1'b1;
        for (int off = 1; off <= NUM_CORES; off++) begin
            idx = int'(i_start) + off;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (o_none && i_mask[idx[ID_W-1:0]]) begin
                o_none    = 1'b0;
                o_next_id = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_grant_arbiter.sv
// mem_grant_arbiter
// -----------------
// Round-robin grant engine between the cores and the shared memory port.
// Picks the next requester after the last served core, drives a registered
// one-hot grant, and holds it until the owner releases it (done pulse or
// request drop) or MAX_HOLD cycles elapse, at which point it is revoked.
// Ports:
//   i_clk         in  system clock, rising edge
//   i_reset_n     in  synchronous active-low reset
//   i_req         in  per-core request level
//   i_done        in  per-core release pulse (only the owner's bit matters)
//   o_gnt         out registered one-hot grant, zero when no owner
//   o_gnt_valid   out OR of o_gnt
//   o_gnt_id      out current owner id, holds last owner when idle
//   o_timeout     out one-cycle pulse on forced revocation
//   o_timeout_id  out id of the revoked core, valid with o_timeout

import mem_grant_arbiter_pkg::*;

module mem_grant_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [`CORES_RANGE]   i_req,
    input  logic [`CORES_RANGE]   i_done,
    output logic [`CORES_RANGE]   o_gnt,
    output logic                  o_gnt_valid,
    output logic [`CORE_ID_RANGE] o_gnt_id,
    output logic                  o_timeout,
    output logic [`CORE_ID_RANGE] o_timeout_id
);

    localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]            r_state;
    logic [`CORES_RANGE]   r_gnt;
    logic [`CORE_ID_RANGE] r_gnt_id;
    logic [`CORE_ID_RANGE] r_last_id;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_timeout;
    logic [`CORE_ID_RANGE] r_timeout_id;

    logic [`CORE_ID_RANGE] w_sel;
    logic                  w_none;
    logic                  w_release;

    rr_next_id u_rr_next_id (
        .i_mask    (i_req),
        .i_start   (r_last_id),
        .o_next_id (w_sel),
        .o_none    (w_none)
    );

    // The owner gives up the port either by pulsing its done bit or by
    // dropping its request; bits of other cores are ignored here.
    assign w_release = i_done[r_gnt_id] | ~i_req[r_gnt_id];

    // FSM, hold counter and output registers. last_id resets to the highest
    // id so that core 0 is scanned first after reset. A release that lands on
    // the timeout cycle takes precedence, so no timeout pulse is raised.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_last_id    <= `CORE_ID_SIZE'(NUM_CORES - 1);
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_none) begin
                        r_gnt      <= onehot(w_sel);
                        r_gnt_id   <= w_sel;
                        r_last_id  <= w_sel;
                        r_hold_cnt <= '0;
                        r_state    <= ST_BUSY;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_gnt        <= '0;
                        r_timeout    <= 1'b1;
                        r_timeout_id <= r_gnt_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_gnt_valid  = |r_gnt;
    assign o_gnt_id     = r_gnt_id;
    assign o_timeout    = r_timeout;
    assign o_timeout_id = r_timeout_id;

endmodule

// File: tb/tb_mem_grant_arbiter.sv
// tb_mem_grant_arbiter
// --------------------
// Directed bench for mem_grant_arbiter with four cores and MAX_HOLD=8.
// Each scenario task drives the request/done lines and compares the packed
// output vector {gnt, gnt_valid, gnt_id, timeout, timeout_id} against
// hand-derived values.

`ifndef NUM_OF_CORES
`define NUM_OF_CORES 4
`endif
`ifndef CORE_ID_SIZE
`define CORE_ID_SIZE 2
`endif
`ifndef CORES_RANGE
`define CORES_RANGE `NUM_OF_CORES-1:0
`endif
`ifndef CORE_ID_RANGE
`define CORE_ID_RANGE `CORE_ID_SIZE-1:0
`endif

module tb_mem_grant_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic [1:0] timeout_id;

    int testsRun;
    int testsFailed;

    mem_grant_arbiter #(.MAX_HOLD(8)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_req        (req),
        .i_done       (done),
        .o_gnt        (gnt),
        .o_gnt_valid  (gnt_valid),
        .o_gnt_id     (gnt_id),
        .o_timeout    (timeout),
        .o_timeout_id (timeout_id)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then move 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packed output; gnt_valid is always the OR of the grant.
    function automatic logic [9:0] mk(input logic [3:0] g, input logic [1:0] id,
                                      input logic to, input logic [1:0] tid);
        return {g, |g, id, to, tid};
    endfunction

    function automatic logic [9:0] obsv();
        return {gnt, gnt_valid, gnt_id, timeout, timeout_id};
    endfunction

    // Reset holds every output at zero and nothing is granted without requests.
    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        done    = 4'b0000;
        tick();
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got %h expected %h", obsv(), mk(4'b0000, 2'd0, 1'b0, 2'd0));
        end
        reset_n = 1'b1;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_req: got %h expected %h", obsv(), mk(4'b0000, 2'd0, 1'b0, 2'd0));
        end
    endtask

    // All four cores request; done is pulsed two cycles after each grant.
    // Order must be 0,1,2,3,0 with one zero cycle between owners.
    task automatic test_round_robin();
        logic [1:0] id;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            id = 2'(i % 4);
            testsRun++;
            if (obsv() !== mk(4'b0001 << id, id, 1'b0, 2'd0)) begin
                testsFailed++;
                $display("[TB] FAIL rr_grant%0d: got %h expected %h", i, obsv(), mk(4'b0001 << id, id, 1'b0, 2'd0));
            end
            tick();
            testsRun++;
            if (obsv() !== mk(4'b0001 << id, id, 1'b0, 2'd0)) begin
                testsFailed++;
                $display("[TB] FAIL rr_hold%0d: got %h expected %h", i, obsv(), mk(4'b0001 << id, id, 1'b0, 2'd0));
            end
            done = 4'b0001 << id;
            tick();
            done = 4'b0000;
            testsRun++;
            if (obsv() !== mk(4'b0000, id, 1'b0, 2'd0)) begin
                testsFailed++;
                $display("[TB] FAIL rr_bubble%0d: got %h expected %h", i, obsv(), mk(4'b0000, id, 1'b0, 2'd0));
            end
            if (i == 4) req = 4'b0000;
            tick();
        end
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL rr_idle: got %h expected %h", obsv(), mk(4'b0000, 2'd0, 1'b0, 2'd0));
        end
    endtask

    // With last_id=1 and requests 1001, core 3 comes before core 0.
    task automatic test_priority_skip();
        req = 4'b0010;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0010, 2'd1, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL prio_setup: got %h expected %h", obsv(), mk(4'b0010, 2'd1, 1'b0, 2'd0));
        end
        done = 4'b0010;
        tick();
        done = 4'b0000;
        req  = 4'b1001;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b1000, 2'd3, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL prio_id3_first: got %h expected %h", obsv(), mk(4'b1000, 2'd3, 1'b0, 2'd0));
        end
        done = 4'b1000;
        tick();
        done = 4'b0000;
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd3, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL prio_hold_last_id: got %h expected %h", obsv(), mk(4'b0000, 2'd3, 1'b0, 2'd0));
        end
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0001, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL prio_id0_next: got %h expected %h", obsv(), mk(4'b0001, 2'd0, 1'b0, 2'd0));
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // A lone requester that never releases is held exactly 8 cycles, revoked
    // with a one-cycle timeout pulse, then re-granted after one bubble.
    task automatic test_timeout();
        req = 4'b0010;
        tick();
        for (int m = 0; m < 8; m++) begin
            testsRun++;
            if (obsv() !== mk(4'b0010, 2'd1, 1'b0, 2'd0)) begin
                testsFailed++;
                $display("[TB] FAIL to_held%0d: got %h expected %h", m, obsv(), mk(4'b0010, 2'd1, 1'b0, 2'd0));
            end
            if (m < 7) tick();
        end
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd1, 1'b1, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL to_pulse: got %h expected %h", obsv(), mk(4'b0000, 2'd1, 1'b1, 2'd1));
        end
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0010, 2'd1, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL to_regrant: got %h expected %h", obsv(), mk(4'b0010, 2'd1, 1'b0, 2'd1));
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Owner 2 releases on the would-be timeout cycle: release wins. A done
    // pulse on core 0 meanwhile is ignored.
    task automatic test_done_vs_timeout();
        req = 4'b0100;
        tick();
        for (int m = 1; m <= 7; m++) begin
            done = (m == 3) ? 4'b0001 : 4'b0000;
            tick();
            testsRun++;
            if (obsv() !== mk(4'b0100, 2'd2, 1'b0, 2'd1)) begin
                testsFailed++;
                $display("[TB] FAIL dvt_hold%0d: got %h expected %h", m, obsv(), mk(4'b0100, 2'd2, 1'b0, 2'd1));
            end
        end
        done = 4'b0100;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd2, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL dvt_release_wins: got %h expected %h", obsv(), mk(4'b0000, 2'd2, 1'b0, 2'd1));
        end
        tick();
    endtask

    // Owner 2 drops its request without done; pending core 3 follows after
    // one bubble. A non-owner request change does nothing.
    task automatic test_req_drop();
        req = 4'b0100;
        tick();
        req = 4'b1100;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0100, 2'd2, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL drop_owner: got %h expected %h", obsv(), mk(4'b0100, 2'd2, 1'b0, 2'd1));
        end
        req = 4'b1000;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd2, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL drop_release: got %h expected %h", obsv(), mk(4'b0000, 2'd2, 1'b0, 2'd1));
        end
        tick();
        testsRun++;
        if (obsv() !== mk(4'b1000, 2'd3, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL drop_next_id3: got %h expected %h", obsv(), mk(4'b1000, 2'd3, 1'b0, 2'd1));
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Reset while BUSY clears everything without a timeout pulse; afterwards
    // core 0 has top priority again.
    task automatic test_reset_busy();
        req = 4'b0010;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0010, 2'd1, 1'b0, 2'd1)) begin
            testsFailed++;
            $display("[TB] FAIL rstb_setup: got %h expected %h", obsv(), mk(4'b0010, 2'd1, 1'b0, 2'd1));
        end
        req     = 4'b1111;
        reset_n = 1'b0;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0000, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL rstb_cleared: got %h expected %h", obsv(), mk(4'b0000, 2'd0, 1'b0, 2'd0));
        end
        reset_n = 1'b1;
        tick();
        testsRun++;
        if (obsv() !== mk(4'b0001, 2'd0, 1'b0, 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL rstb_id0_first: got %h expected %h", obsv(), mk(4'b0001, 2'd0, 1'b0, 2'd0));
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        req         = 4'b0000;
        done        = 4'b0000;
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_round_robin();
        test_priority_skip();
        test_timeout();
        test_done_vs_timeout();
        test_req_drop();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
